// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the pipelined ALU-control stage: ALUOp, funct/opcode
// encodings, 4-bit ALU codes and the mult/div sequencer states.
package alu_ctrl_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;

    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_MULT = 4'b1101;
    localparam logic [3:0] ALU_DIV  = 4'b1110;
    localparam logic [3:0] ALU_LUI  = 4'b1111;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        MULDIV = 1'b1
    } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU-control decode: ALUOp plus funct (R-type) or opcode
// (I-type) into a 4-bit ALU code, an illegal flag and a mult/div marker.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    input  logic [5:0] opcode,
    output logic [3:0] code,
    output logic       illegal,
    output logic       is_muldiv
);

    always_comb begin
        code      = ALU_ADD;
        illegal   = 1'b0;
        is_muldiv = 1'b0;
        unique case (alu_op)
            ALUOP_ADD: code = ALU_ADD;
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU: code = ALU_ADD;
                    F_SUB, F_SUBU: code = ALU_SUB;
                    F_AND:         code = ALU_AND;
                    F_OR:          code = ALU_OR;
                    F_XOR:         code = ALU_XOR;
                    F_NOR:         code = ALU_NOR;
                    F_SLT:         code = ALU_SLT;
                    F_SLTU:        code = ALU_SLTU;
                    F_SLL:         code = ALU_SLL;
                    F_SRL:         code = ALU_SRL;
                    F_SRA:         code = ALU_SRA;
                    F_MULT: begin
                        code      = ALU_MULT;
                        is_muldiv = 1'b1;
                    end
                    F_DIV: begin
                        code      = ALU_DIV;
                        is_muldiv = 1'b1;
                    end
                    default:       illegal = 1'b1;
                endcase
            end
            ALUOP_ITYPE: begin
                case (opcode)
                    OP_ADDI, OP_ADDIU: code = ALU_ADD;
                    OP_ANDI:           code = ALU_AND;
                    OP_ORI:            code = ALU_OR;
                    OP_XORI:           code = ALU_XOR;
                    OP_SLTI:           code = ALU_SLT;
                    OP_SLTIU:          code = ALU_SLTU;
                    OP_LUI:            code = ALU_LUI;
                    default:           illegal = 1'b1;
                endcase
            end
            default: code = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_control_pipe.sv
// Registered ALU-control stage at the ID/EX boundary with valid/ready,
// stall, flush and a busy counter sequencing multi-cycle mult/div.
module alu_control_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W        = 4,
    parameter int MULDIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic [5:0]        opcode,
    input  logic              stall_in,
    input  logic              flush,
    output logic              out_valid,
    output logic [CTRL_W-1:0] alu_ctl,
    output logic              illegal,
    output logic              muldiv_start,
    output logic              muldiv_done,
    output logic              muldiv_busy
);

    localparam int CNT_W = $clog2(MULDIV_CYCLES);

    logic [3:0]        w_code;
    logic              w_illegal;
    logic              w_is_muldiv;
    logic              w_accept;

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_out_valid;
    logic [CTRL_W-1:0] r_alu_ctl;
    logic              r_illegal;
    logic              r_start;
    logic              r_done;

    alu_ctrl_decode u_decode (
        .alu_op    (alu_op),
        .funct     (funct),
        .opcode    (opcode),
        .code      (w_code),
        .illegal   (w_illegal),
        .is_muldiv (w_is_muldiv)
    );

    assign in_ready = (r_state == IDLE) && !stall_in && !flush;
    assign w_accept = in_valid && in_ready;

    // done is registered off counter==1 so it lands on the last busy cycle
    // (counter==0); the FSM leaves MULDIV on the edge that ends that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_alu_ctl   <= '0;
            r_illegal   <= 1'b0;
            r_start     <= 1'b0;
            r_done      <= 1'b0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
            r_start     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_start <= w_accept && w_is_muldiv;
            r_done  <= (r_state == MULDIV) && (r_cnt == CNT_W'(1));

            if (r_state == IDLE) begin
                if (w_accept && w_is_muldiv) begin
                    r_state <= MULDIV;
                    r_cnt   <= CNT_W'(MULDIV_CYCLES - 1);
                end
            end else if (r_cnt == '0) begin
                r_state <= IDLE;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (!stall_in) begin
                if (w_accept) begin
                    r_out_valid <= 1'b1;
                    r_alu_ctl   <= CTRL_W'(w_code);
                    r_illegal   <= w_illegal;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign alu_ctl      = r_alu_ctl;
    assign illegal      = r_illegal;
    assign muldiv_start = r_start;
    assign muldiv_done  = r_done;
    assign muldiv_busy  = (r_state == MULDIV);

endmodule

// File: tb/tb_alu_control_pipe.sv
// Self-checking bench for alu_control_pipe (CTRL_W=6, MULDIV_CYCLES=4).
module tb_alu_control_pipe;

    localparam int CW = 6;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    alu_op;
    logic [5:0]    funct;
    logic [5:0]    opcode;
    logic          stall_in;
    logic          flush;
    logic          out_valid;
    logic [CW-1:0] alu_ctl;
    logic          illegal;
    logic          muldiv_start;
    logic          muldiv_done;
    logic          muldiv_busy;

    typedef struct {
        logic [3:0] code;
        logic       ill;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu_control_pipe #(
        .CTRL_W        (CW),
        .MULDIV_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_op       (alu_op),
        .funct        (funct),
        .opcode       (opcode),
        .stall_in     (stall_in),
        .flush        (flush),
        .out_valid    (out_valid),
        .alu_ctl      (alu_ctl),
        .illegal      (illegal),
        .muldiv_start (muldiv_start),
        .muldiv_done  (muldiv_done),
        .muldiv_busy  (muldiv_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive inputs, check in_ready before the edge, and if the op
    // is expected to be accepted, score its registered result after the edge.
    task automatic step(input logic v, input logic [1:0] aop, input logic [5:0] f,
                        input logic [5:0] opc, input logic st, input logic fl,
                        input logic exp_rdy, input logic [3:0] exp_code,
                        input logic exp_ill, input string name);
        exp_t e;
        in_valid = v; alu_op = aop; funct = f; opcode = opc;
        stall_in = st; flush = fl;
        #1;
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL %s in_ready: got %b expected %b", name, in_ready, exp_rdy);
        end
        if (v && exp_rdy) begin
            e.code = exp_code;
            e.ill  = exp_ill;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        if (v && exp_rdy) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL %s scoreboard empty", name);
            end else begin
                e = sb.pop_front();
                if ({out_valid, alu_ctl, illegal} !== {1'b1, CW'(e.code), e.ill}) begin
                    errors++;
                    $display("FAIL %s result: got v=%b ctl=%b ill=%b expected v=1 ctl=%b ill=%b",
                             name, out_valid, alu_ctl, illegal, CW'(e.code), e.ill);
                end
            end
        end
    endtask

    task automatic idle();
        in_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
        alu_op = 2'b00; funct = '0; opcode = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, alu_ctl, illegal, muldiv_start, muldiv_done, muldiv_busy, in_ready}
            !== {1'b0, {CW{1'b0}}, 5'b00001}) begin
            errors++;
            $display("FAIL reset_state: got v=%b ctl=%b ill=%b st=%b dn=%b bz=%b rdy=%b expected zeros, rdy=1",
                     out_valid, alu_ctl, illegal, muldiv_start, muldiv_done, muldiv_busy, in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_rtype_stream();
        logic [5:0] fs [7];
        logic [3:0] cs [7];
        fs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000011};
        cs = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100, 4'b1011};
        for (int i = 0; i < 7; i++)
            step(1'b1, 2'b10, fs[i], 6'b0, 1'b0, 1'b0, 1'b1, cs[i], 1'b0, "rtype_stream");
        // remaining R-type codes plus ALUOp 00/01 and the unsigned aliases
        fs = '{6'b100110, 6'b101011, 6'b000000, 6'b000010, 6'b100001, 6'b100011, 6'b111111};
        cs = '{4'b0011, 4'b1000, 4'b1001, 4'b1010, 4'b0010, 4'b0110, 4'b0010};
        for (int i = 0; i < 7; i++)
            step(1'b1, 2'b10, fs[i], 6'b0, 1'b0, 1'b0, 1'b1, cs[i], (i == 6), "rtype_more");
        step(1'b1, 2'b00, 6'b101010, 6'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, "aluop_00");
        step(1'b1, 2'b01, 6'b100101, 6'b0, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, "aluop_01");
        step(1'b0, 2'b00, 6'b0, 6'b0, 1'b0, 1'b0, 1'b1, 4'b0, 1'b0, "bubble");
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bubble out_valid: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_itype();
        logic [5:0] os [8];
        logic [3:0] cs [8];
        os = '{6'b001000, 6'b001101, 6'b001111, 6'b000111, 6'b001001, 6'b001100, 6'b001110, 6'b001011};
        cs = '{4'b0010, 4'b0001, 4'b1111, 4'b0010, 4'b0010, 4'b0000, 4'b0011, 4'b1000};
        for (int i = 0; i < 8; i++)
            step(1'b1, 2'b11, 6'b0, os[i], 1'b0, 1'b0, 1'b1, cs[i], (i == 3), "itype");
        step(1'b1, 2'b11, 6'b0, 6'b001010, 1'b0, 1'b0, 1'b1, 4'b0111, 1'b0, "itype_slti");
    endtask

    task automatic test_muldiv();
        step(1'b1, 2'b10, 6'b011000, 6'b0, 1'b0, 1'b0, 1'b1, 4'b1101, 1'b0, "mult_accept");
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if ({muldiv_busy, muldiv_start, muldiv_done} !== {1'b1, (k == 1), (k == 4)}) begin
                errors++;
                $display("FAIL muldiv_cycle%0d: got busy=%b start=%b done=%b expected busy=1 start=%b done=%b",
                         k, muldiv_busy, muldiv_start, muldiv_done, (k == 1), (k == 4));
            end
            step(1'b1, 2'b00, 6'b0, 6'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, "mult_busy_ready");
        end
        checks++;
        if ({muldiv_busy, muldiv_start, muldiv_done, out_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL mult_after: got busy=%b start=%b done=%b v=%b expected all 0",
                     muldiv_busy, muldiv_start, muldiv_done, out_valid);
        end
        step(1'b1, 2'b10, 6'b100101, 6'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, "after_mult");
    endtask

    task automatic test_stall();
        step(1'b1, 2'b10, 6'b100101, 6'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, "stall_or");
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 2'b10, 6'b100000, 6'b0, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0, "stall_ready");
            checks++;
            if ({out_valid, alu_ctl, illegal} !== {1'b1, CW'(4'b0001), 1'b0}) begin
                errors++;
                $display("FAIL stall_hold: got v=%b ctl=%b ill=%b expected v=1 ctl=%b ill=0",
                         out_valid, alu_ctl, illegal, CW'(4'b0001));
            end
        end
        step(1'b1, 2'b10, 6'b100010, 6'b0, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, "stall_release");
    endtask

    task automatic test_flush();
        step(1'b1, 2'b11, 6'b0, 6'b000111, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, "flush_illegal_op");
        step(1'b1, 2'b00, 6'b0, 6'b0, 1'b0, 1'b1, 1'b0, 4'b0, 1'b0, "flush_ready");
        checks++;
        if ({out_valid, illegal} !== 2'b00) begin
            errors++;
            $display("FAIL flush_clear: got v=%b ill=%b expected 0 0", out_valid, illegal);
        end
        step(1'b1, 2'b10, 6'b011010, 6'b0, 1'b0, 1'b0, 1'b1, 4'b1110, 1'b0, "div_accept");
        step(1'b0, 2'b00, 6'b0, 6'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, "div_c1");
        step(1'b0, 2'b00, 6'b0, 6'b0, 1'b0, 1'b1, 1'b0, 4'b0, 1'b0, "div_flush");
        flush = 1'b0;
        #1;
        checks++;
        if ({muldiv_busy, out_valid, muldiv_done, in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL div_flushed: got busy=%b v=%b done=%b rdy=%b expected 0 0 0 1",
                     muldiv_busy, out_valid, muldiv_done, in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 2'b00, 6'b0, 6'b0, 1'b0, 1'b0, 1'b1, 4'b0, 1'b0, "post_flush_ready");
            checks++;
            if (muldiv_done !== 1'b0) begin
                errors++;
                $display("FAIL post_flush_done: got %b expected 0", muldiv_done);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 2'b10, 6'b011000, 6'b0, 1'b0, 1'b0, 1'b1, 4'b1101, 1'b0, "rst_mult");
        step(1'b0, 2'b00, 6'b0, 6'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, "rst_mult_c1");
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, alu_ctl, illegal, muldiv_start, muldiv_done, muldiv_busy}
            !== {1'b0, {CW{1'b0}}, 4'b0000}) begin
            errors++;
            $display("FAIL rst_mid_muldiv: got v=%b ctl=%b ill=%b st=%b dn=%b bz=%b expected zeros",
                     out_valid, alu_ctl, illegal, muldiv_start, muldiv_done, muldiv_busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b1, 2'b10, 6'b100111, 6'b0, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0, "rst_release_op");
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, alu_ctl} !== {1'b0, {CW{1'b0}}}) begin
            errors++;
            $display("FAIL rst_mid_stream: got v=%b ctl=%b expected zeros", out_valid, alu_ctl);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b1, 2'b11, 6'b0, 6'b001111, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, "rst_release_lui");
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_rtype_stream();
        test_itype();
        test_muldiv();
        test_stall();
        test_flush();
        test_reset_mid();
        idle();
        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
